// File: rtl/btn_debounce_pkg.sv
// Shared board constants and per-channel debounce FSM encoding.
// Imported by the debounce interface, channel and top modules.
package btn_debounce_pkg;

   localparam int unsigned CLK_FREQ_HZ       = 12_000_000;
   localparam int unsigned DEBOUNCE_MS       = 5;
   localparam int unsigned DEF_STABLE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

   typedef enum logic {
      ST_RELEASED = 1'b0,
      ST_PRESSED  = 1'b1
   } chan_state_e;

   function automatic chan_state_e chan_toggle(input chan_state_e s);
      return (s == ST_PRESSED) ? ST_RELEASED : ST_PRESSED;
   endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw levels in, debounced level/pulses/count out.
// master drives the raw buttons, slave is the debouncer.
interface btn_debounce_if #(
   parameter int N_BTN = 4
);

   logic [N_BTN-1:0] BTN_IN;
   logic [N_BTN-1:0] BTN_STATE;
   logic [N_BTN-1:0] BTN_PRESS;
   logic [N_BTN-1:0] BTN_RELEASE;
   logic [7:0]       PRESS_CNT;

   modport master (
      output BTN_IN,
      input  BTN_STATE,
      input  BTN_PRESS,
      input  BTN_RELEASE,
      input  PRESS_CNT
   );

   modport slave (
      input  BTN_IN,
      output BTN_STATE,
      output BTN_PRESS,
      output BTN_RELEASE,
      output PRESS_CNT
   );

endinterface

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF sync, stability counter, 2-state FSM
// and registered press/release pulses.
module btn_debounce_chan
   import btn_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic CLK_IN,
   input  logic RST_IN,
   input  logic BTN_RAW,
   output logic BTN_STATE,
   output logic BTN_PRESS,
   output logic BTN_RELEASE
);

   localparam int unsigned    CW       = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic          raw_pol;
   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   chan_state_e   state_q;
   chan_state_e   state_d;
   logic          press_q;
   logic          press_d;
   logic          release_q;
   logic          release_d;
   logic          level;

   assign raw_pol = ACTIVE_LOW ? ~BTN_RAW : BTN_RAW;
   assign level   = (state_q == ST_PRESSED);

   // Two-stage synchronizer on the polarity-corrected input.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_pol;
         sync2_q <= sync1_q;
      end
   end

   // State, stability counter and pulse registers.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_q   <= ST_RELEASED;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Count disagreement cycles; toggle once the new level has held long enough.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q == level) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         state_d = chan_toggle(state_q);
         unique case (state_q)
            ST_RELEASED: press_d   = 1'b1;
            ST_PRESSED:  release_d = 1'b1;
            default: ;
         endcase
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign BTN_STATE   = level;
   assign BTN_PRESS   = press_q;
   assign BTN_RELEASE = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with a channel-0 press counter.
// Each bit gets its own btn_debounce_chan instance.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int          N_BTN         = 4,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic           CLK_IN,
   input  logic           RST_IN,
   btn_debounce_if.slave  BUS
);

   logic [N_BTN-1:0] state_w;
   logic [N_BTN-1:0] press_w;
   logic [N_BTN-1:0] release_w;
   logic [7:0]       press_cnt_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_chan (
         .CLK_IN      (CLK_IN),
         .RST_IN      (RST_IN),
         .BTN_RAW     (BUS.BTN_IN[i]),
         .BTN_STATE   (state_w[i]),
         .BTN_PRESS   (press_w[i]),
         .BTN_RELEASE (release_w[i])
      );
   end

   // Channel-0 press counter, wraps modulo 256.
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         press_cnt_q <= '0;
      end else if (press_w[0]) begin
         press_cnt_q <= press_cnt_q + 8'd1;
      end
   end

   assign BUS.BTN_STATE   = state_w;
   assign BUS.BTN_PRESS   = press_w;
   assign BUS.BTN_RELEASE = release_w;
   assign BUS.PRESS_CNT   = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4, ACTIVE_LOW=0.
// Expected pulse edges are hand-computed as k+5 from the input change.
module tb_btn_debounce;

   logic CLK_IN = 1'b0;
   logic RST_IN;
   int   n_asserts = 0;
   int   n_fails   = 0;
   logic [3:0] seen;

   btn_debounce_if #(.N_BTN(4)) bus ();

   btn_debounce #(
      .N_BTN         (4),
      .STABLE_CYCLES (4),
      .ACTIVE_LOW    (1'b0)
   ) dut (
      .CLK_IN (CLK_IN),
      .RST_IN (RST_IN),
      .BUS    (bus)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic tick();
      @(posedge CLK_IN);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RST_IN     = 1'b1;
      bus.BTN_IN = '0;
      tick();
      tick();
      check("rst_state",   32'(bus.BTN_STATE),   32'(0));
      check("rst_press",   32'(bus.BTN_PRESS),   32'(0));
      check("rst_release", 32'(bus.BTN_RELEASE), 32'(0));
      check("rst_cnt",     32'(bus.PRESS_CNT),   32'(0));
      RST_IN = 1'b0;
      repeat (3) tick();
      check("idle_state", 32'(bus.BTN_STATE), 32'(0));

      // clean press on channel 0
      bus.BTN_IN[0] = 1'b1;
      seen = '0;
      repeat (5) begin
         tick();
         seen |= bus.BTN_PRESS | bus.BTN_STATE;
      end
      check("press0_early", 32'(seen), 32'(0));
      tick();
      check("press0_state", 32'(bus.BTN_STATE), 32'(4'b0001));
      check("press0_pulse", 32'(bus.BTN_PRESS), 32'(4'b0001));
      check("press0_cnt0",  32'(bus.PRESS_CNT), 32'(0));
      tick();
      check("press0_end",   32'(bus.BTN_PRESS), 32'(0));
      check("press0_cnt1",  32'(bus.PRESS_CNT), 32'(1));

      // bounce on channel 1
      seen = '0;
      bus.BTN_IN[1] = 1'b1; tick(); seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      bus.BTN_IN[1] = 1'b0; tick(); seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      bus.BTN_IN[1] = 1'b1; tick(); seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      bus.BTN_IN[1] = 1'b0; tick(); seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      bus.BTN_IN[1] = 1'b1;
      repeat (5) begin
         tick();
         seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      end
      check("bounce_no_pulse", 32'(seen), 32'(0));
      check("bounce_state0",   32'(bus.BTN_STATE), 32'(4'b0001));
      tick();
      check("bounce_pulse",    32'(bus.BTN_PRESS), 32'(4'b0010));
      check("bounce_state1",   32'(bus.BTN_STATE), 32'(4'b0011));
      tick();
      check("bounce_end",      32'(bus.BTN_PRESS), 32'(0));

      // release on channel 2
      bus.BTN_IN[2] = 1'b1;
      repeat (7) tick();
      check("rel_pressed", 32'(bus.BTN_STATE), 32'(4'b0111));
      bus.BTN_IN[2] = 1'b0;
      seen = '0;
      repeat (5) begin
         tick();
         seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      end
      check("rel_early",  32'(seen), 32'(0));
      tick();
      check("rel_pulse",  32'(bus.BTN_RELEASE), 32'(4'b0100));
      check("rel_nopress", 32'(bus.BTN_PRESS),  32'(0));
      check("rel_state",  32'(bus.BTN_STATE),   32'(4'b0011));
      tick();
      check("rel_end",    32'(bus.BTN_RELEASE), 32'(0));

      // fresh start for the wrap test
      bus.BTN_IN = '0;
      RST_IN = 1'b1;
      tick();
      tick();
      RST_IN = 1'b0;
      tick();
      check("wrap_start", 32'(bus.PRESS_CNT), 32'(0));

      for (int i = 0; i < 256; i++) begin
         bus.BTN_IN[0] = 1'b1;
         bus.BTN_IN[3] = 1'b1;
         seen = '0;
         repeat (5) begin
            tick();
            seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
         end
         tick();
         check("wrap_press",
               32'({seen[3], seen[0], bus.BTN_PRESS[3], bus.BTN_PRESS[0]}),
               32'(4'b0011));
         tick();
         check("wrap_cnt", 32'(bus.PRESS_CNT), 32'((i + 1) % 256));
         bus.BTN_IN[0] = 1'b0;
         bus.BTN_IN[3] = 1'b0;
         seen = '0;
         repeat (5) begin
            tick();
            seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
         end
         tick();
         check("wrap_release",
               32'({seen[3], seen[0], bus.BTN_RELEASE[3], bus.BTN_RELEASE[0]}),
               32'(4'b0011));
      end
      check("wrap_zero", 32'(bus.PRESS_CNT), 32'(0));

      // reset mid-count on ch0 and mid-pulse on ch3
      tick();
      bus.BTN_IN[3] = 1'b1;
      tick();
      tick();
      bus.BTN_IN[0] = 1'b1;
      repeat (4) tick();
      check("pre_rst_pulse", 32'(bus.BTN_PRESS), 32'(4'b1000));
      check("pre_rst_state", 32'(bus.BTN_STATE), 32'(4'b1000));
      #1;
      RST_IN = 1'b1;
      #1;
      check("async_state",   32'(bus.BTN_STATE),   32'(0));
      check("async_press",   32'(bus.BTN_PRESS),   32'(0));
      check("async_release", 32'(bus.BTN_RELEASE), 32'(0));
      check("async_cnt",     32'(bus.PRESS_CNT),   32'(0));
      tick();
      tick();
      RST_IN = 1'b0;
      seen = '0;
      repeat (5) begin
         tick();
         seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      end
      check("post_rst_early", 32'(seen), 32'(0));
      tick();
      check("post_rst_press", 32'(bus.BTN_PRESS), 32'(4'b1001));
      tick();
      check("post_rst_end",   32'(bus.BTN_PRESS), 32'(0));
      check("post_rst_cnt",   32'(bus.PRESS_CNT), 32'(1));
      seen = '0;
      repeat (8) begin
         tick();
         seen |= bus.BTN_PRESS | bus.BTN_RELEASE;
      end
      check("post_rst_once",  32'(seen), 32'(0));
      check("post_rst_state", 32'(bus.BTN_STATE), 32'(4'b1001));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels.
REQ-002 Parameter STABLE_CYCLES, default 60000: consecutive stable cycles required to accept a level change (5 ms at 12 MHz). Legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, raw inputs are inverted so that a pressed button reads as logic 1 internally.
REQ-004 CLK_IN  input  1  sole clock; all state on its rising edge.
REQ-005 RST_IN  input  1  reset, asynchronous and active-high.
REQ-006 BTN_IN  input  N_BTN  raw asynchronous button levels, one bit per channel.
REQ-007 BTN_STATE  output  N_BTN  debounced level, 1 = pressed.
REQ-008 BTN_PRESS  output  N_BTN  one-cycle pulse when BTN_STATE rises.
REQ-009 BTN_RELEASE  output  N_BTN  one-cycle pulse when BTN_STATE falls.
REQ-010 PRESS_CNT  output  8  count of BTN_PRESS pulses on channel 0; wraps from 255 to 0.

Function
REQ-011 Each channel SHALL pass its polarity-corrected input through a 2-FF synchronizer (sync1, then sync2) before any other use.
REQ-012 Each channel SHALL hold a counter of width clog2(STABLE_CYCLES), an accepted level (BTN_STATE bit) and a 2-state FSM: RELEASED (state=0) and PRESSED (state=1).
REQ-013 Counter rule: the counter SHALL be cleared to 0 on any cycle where sync2 equals the accepted level, and SHALL increment on any cycle where they differ.
REQ-014 Transition: on the edge where sync2 differs and the counter equals STABLE_CYCLES-1, the FSM SHALL toggle state, clear the counter, and assert the matching pulse in the same cycle as BTN_STATE changes.
REQ-015 Latency: an input level change held stable from edge k SHALL be reflected on BTN_STATE at edge k+1+STABLE_CYCLES (2 sync stages plus STABLE_CYCLES compare cycles).
REQ-016 Bounce: any glitch shorter than STABLE_CYCLES cycles at sync2 SHALL produce no change and no pulse. Each return to the accepted level restarts the count from 0.
REQ-017 BTN_PRESS and BTN_RELEASE SHALL be high for exactly one cycle per transition and SHALL never be high simultaneously on the same channel.
REQ-018 Channels SHALL be fully independent. Simultaneous transitions on several channels SHALL each pulse in the same cycle.
REQ-019 PRESS_CNT SHALL increment by 1 in the cycle after each channel-0 BTN_PRESS pulse, wrapping modulo 256.
REQ-020 Outputs SHALL be registered. There SHALL be no combinational path from BTN_IN to any output.

Reset
REQ-021 While RST_IN is high, the following SHALL be forced to 0 immediately, independent of CLK_IN: sync1, sync2, counters, BTN_STATE, BTN_PRESS, BTN_RELEASE and PRESS_CNT. Sync stages reset to the internal released level (0).
REQ-022 Reset asserted mid-count or mid-pulse SHALL abort the count and truncate the pulse, with no pulse after release.
REQ-023 A button held through reset release SHALL be treated as a new press: BTN_PRESS fires once, following the REQ-015 latency measured from the first post-reset edge.

Structure
REQ-024 The board clock frequency constant (12 MHz) and the default STABLE_CYCLES SHALL live in the shared board package. Per-channel FSM state encodings SHALL live in the same package.
REQ-025 One sub-module, btn_debounce_chan (synchronizer, counter, FSM, pulses for one bit), SHALL be instantiated N_BTN times. PRESS_CNT SHALL reside in the top module.

Verification (bench uses STABLE_CYCLES=4, ACTIVE_LOW=0, N_BTN=4)
REQ-026 Clean press: BTN_IN[0] 0->1 before edge k and held -> BTN_STATE[0]=1 and BTN_PRESS[0]=1 at edge k+5 only; PRESS_CNT=1 at edge k+6.
REQ-027 Bounce: BTN_IN[1] toggles 1,0,1,0 at 1-cycle spacing, then holds 1 -> no pulse during the bounce; one BTN_PRESS[1] 5 cycles after the final rise.
REQ-028 Release: from pressed, BTN_IN[2] 1->0 held -> BTN_RELEASE[2] single pulse at edge k+5, BTN_STATE[2]=0, and BTN_PRESS[2] stays 0.
REQ-029 Wrap and simultaneity: 256 clean presses on channel 0 with channel 3 pressed at the same time -> PRESS_CNT returns to 0, and both channels pulse in the same cycle each time.
REQ-030 Reset mid-operation: assert RST_IN 2 cycles into a count, with BTN_IN[0] held at 1 -> all outputs 0 asynchronously; after release, exactly one BTN_PRESS[0] 5 cycles later.
